// File: rtl/mem_loader.sv
// mem_loader
//   Streams a data image and then an instruction image into the CPU's two
//   external memory ports, waits a short settle time, then enables the CPU
//   and counts its run cycles until it fetches the stop opcode.
//
// Ports
//   clk, arst_n          rising-edge clock, asynchronous active-low reset
//   start                one-cycle pulse; begins a load from IDLE or HALT
//   in_valid, in_data    source word stream (imem phase uses [31:0])
//   in_ready             a word is accepted on in_valid & in_ready
//   stop_seen            CPU fetched the stop opcode (only honoured in RUN)
//   *_ext                instruction-memory port (32-bit data)
//   *_ext_2              data-memory port (64-bit data)
//   cpu_enable           high in RUN only
//   busy, done           busy outside IDLE/HALT; done in HALT
//   cycles               number of clk edges seen with cpu_enable high
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start after reset
// LOAD_DMEM | accepting data words, writing the data-memory port
// LOAD_IMEM | accepting instruction words, writing the instr-memory port
// SETTLE    | last write pulse, then SETTLE_CYCLES idle cycles
// RUN       | CPU enabled, cycle counter running
// HALT      | stop opcode seen; results held until the next start
module mem_loader #(
   parameter int IMEM_WORDS    = 512,
   parameter int DMEM_WORDS    = 1024,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   output logic        in_ready,
   input  logic        stop_seen,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic [31:0] cycles
);

   // One word counter serves both phases, so it is sized for the larger one.
   localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
   localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int SET_W     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_WORDS - 1);
   localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_WORDS - 1);
   localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      IDLE, LOAD_DMEM, LOAD_IMEM, SETTLE, RUN, HALT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [31:0]        cycles_q, cycles_d;
   logic               wen_ext_q, wen_ext_d;
   logic [63:0]        addr_ext_q, addr_ext_d;
   logic [31:0]        wdata_ext_q, wdata_ext_d;
   logic               wen_ext_2_q, wen_ext_2_d;
   logic [63:0]        addr_ext_2_q, addr_ext_2_d;
   logic [63:0]        wdata_ext_2_q, wdata_ext_2_d;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= IDLE;
         word_cnt_q    <= '0;
         settle_cnt_q  <= '0;
         cycles_q      <= '0;
         wen_ext_q     <= 1'b0;
         addr_ext_q    <= '0;
         wdata_ext_q   <= '0;
         wen_ext_2_q   <= 1'b0;
         addr_ext_2_q  <= '0;
         wdata_ext_2_q <= '0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         settle_cnt_q  <= settle_cnt_d;
         cycles_q      <= cycles_d;
         wen_ext_q     <= wen_ext_d;
         addr_ext_q    <= addr_ext_d;
         wdata_ext_q   <= wdata_ext_d;
         wen_ext_2_q   <= wen_ext_2_d;
         addr_ext_2_q  <= addr_ext_2_d;
         wdata_ext_2_q <= wdata_ext_2_d;
      end
   end

   // Write pulses default to zero every cycle, so a port is only ever driven
   // the cycle after its own phase accepts a word; the two ports cannot
   // overlap because only one load state is active at a time.
   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      settle_cnt_d  = settle_cnt_q;
      cycles_d      = cycles_q;
      wen_ext_d     = 1'b0;
      addr_ext_d    = '0;
      wdata_ext_d   = '0;
      wen_ext_2_d   = 1'b0;
      addr_ext_2_d  = '0;
      wdata_ext_2_d = '0;

      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d      = LOAD_DMEM;
               word_cnt_d   = '0;
               settle_cnt_d = '0;
               cycles_d     = '0;
            end
         end
         LOAD_DMEM: begin
            if (in_valid) begin
               wen_ext_2_d   = 1'b1;
               addr_ext_2_d  = 64'(word_cnt_q) << 2;
               wdata_ext_2_d = in_data;
               if (word_cnt_q == DMEM_LAST) begin
                  word_cnt_d = '0;
                  state_d    = LOAD_IMEM;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         LOAD_IMEM: begin
            if (in_valid) begin
               wen_ext_d   = 1'b1;
               addr_ext_d  = 64'(word_cnt_q) << 2;
               wdata_ext_d = in_data[31:0];
               if (word_cnt_q == IMEM_LAST) begin
                  word_cnt_d   = '0;
                  settle_cnt_d = SETTLE_LD;
                  state_d      = SETTLE;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         // First SETTLE cycle carries the last write pulse; the down-counter
         // then supplies the idle cycles before the CPU is enabled.
         SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               settle_cnt_d = settle_cnt_q - 1'b1;
            end
         end
         RUN: begin
            if (cycles_q != 32'hFFFF_FFFF) begin
               cycles_d = cycles_q + 32'd1;
            end
            if (stop_seen) begin
               state_d = HALT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == LOAD_DMEM) || (state_q == LOAD_IMEM);
   assign cpu_enable  = (state_q == RUN);
   assign busy        = (state_q != IDLE) && (state_q != HALT);
   assign done        = (state_q == HALT);
   assign cycles      = cycles_q;
   assign wen_ext     = wen_ext_q;
   assign addr_ext    = addr_ext_q;
   assign wdata_ext   = wdata_ext_q;
   assign ren_ext     = 1'b0;
   assign wen_ext_2   = wen_ext_2_q;
   assign addr_ext_2  = addr_ext_2_q;
   assign wdata_ext_2 = wdata_ext_2_q;
   assign ren_ext_2   = 1'b0;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        stop_seen;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic [31:0] cycles;

   mem_loader #(.IMEM_WORDS(4), .DMEM_WORDS(4), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .stop_seen(stop_seen),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .cycles(cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // write log, sampled mid-cycle
   logic [63:0] d_addr[$];
   logic [63:0] d_data[$];
   logic [63:0] i_addr[$];
   logic [31:0] i_data[$];
   int cyc = 0, last_iwen_cyc = -1, rise_cyc = -1;
   int excl_err = 0, ren_err = 0;
   logic en_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (wen_ext_2) begin
         d_addr.push_back(addr_ext_2);
         d_data.push_back(wdata_ext_2);
      end
      if (wen_ext) begin
         i_addr.push_back(addr_ext);
         i_data.push_back(wdata_ext);
         last_iwen_cyc = cyc;
      end
      if (cpu_enable && !en_prev) rise_cyc = cyc;
      en_prev = cpu_enable;
      if (wen_ext && wen_ext_2) excl_err++;
      if (ren_ext || ren_ext_2) ren_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      d_addr.delete(); d_data.delete(); i_addr.delete(); i_data.delete();
   endtask

   logic [63:0] words [8];

   initial begin
      words[0] = 64'h1111_2222_3333_4444;
      words[1] = 64'h5555_6666_7777_8888;
      words[2] = 64'h9999_AAAA_BBBB_CCCC;
      words[3] = 64'hDDDD_EEEE_FFFF_0001;
      words[4] = 64'hAAAA_0000_0000_0013;
      words[5] = 64'hBBBB_0000_0040_0093;
      words[6] = 64'hCCCC_0000_0080_0113;
      words[7] = 64'hDDDD_0000_0000_007E;

      arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 64'h0; stop_seen = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cpu_en", cpu_enable, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_wen", {wen_ext, wen_ext_2}, 0);
      tick();
      arst_n = 1'b1;
      tick();

      // back-to-back full load, start pulsed mid-imem must be ignored
      pulse_start();
      chk("load_ready", in_ready, 1);
      chk("load_busy", busy, 1);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = words[i];
         start    = (i == 5);
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      begin
         int k;
         for (k = 0; k < 20 && !cpu_enable; k++) tick();
      end
      chk("run_entry", cpu_enable, 1);
      chk("dmem_count", d_addr.size(), 4);
      chk("imem_count", i_addr.size(), 4);
      for (int i = 0; i < 4 && i < d_addr.size(); i++) begin
         chk($sformatf("dmem_addr%0d", i), d_addr[i], 64'(i * 4));
         chk($sformatf("dmem_data%0d", i), d_data[i], words[i]);
      end
      chk("imem_addr0", i_addr.size() > 0 ? i_addr[0] : 64'hX, 64'd0);
      chk("imem_addr3", i_addr.size() > 3 ? i_addr[3] : 64'hX, 64'd12);
      chk("imem_data0", i_data.size() > 0 ? i_data[0] : 32'hX, 32'h0000_0013);
      chk("imem_data1", i_data.size() > 1 ? i_data[1] : 32'hX, 32'h0040_0093);
      chk("imem_data2", i_data.size() > 2 ? i_data[2] : 32'hX, 32'h0080_0113);
      chk("imem_data3", i_data.size() > 3 ? i_data[3] : 32'hX, 32'h0000_007E);

      // now in RUN cycle 1; start at cycle 5 ignored, stop on cycle 10
      for (int i = 2; i <= 10; i++) begin
         start = (i == 5);
         tick();
      end
      start = 1'b0;
      chk("settle_gap", rise_cyc - last_iwen_cyc, 2);
      chk("run_before_stop", cpu_enable, 1);
      stop_seen = 1'b1;
      tick();
      stop_seen = 1'b0;
      chk("halt_done", done, 1);
      chk("halt_cpu_en", cpu_enable, 0);
      chk("halt_busy", busy, 0);
      chk("halt_cycles", cycles, 10);
      repeat (20) tick();
      chk("halt_cycles_held", cycles, 10);
      chk("halt_done_held", done, 1);

      // restart from HALT, stop_seen held during load, gappy valid pattern
      clear_log();
      stop_seen = 1'b1;
      pulse_start();
      chk("restart_cycles_clr", cycles, 0);
      chk("restart_done", done, 0);
      in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; tick();
      in_valid = 1'b0; in_data = 64'hDEAD_BEEF_DEAD_BEEF; tick();
      tick();
      in_valid = 1'b1; in_data = 64'hFEDC_BA98_7654_3210; tick();
      in_valid = 1'b0;
      tick();
      chk("gap_count", d_addr.size(), 2);
      chk("gap_addr0", d_addr.size() > 0 ? d_addr[0] : 64'hX, 64'd0);
      chk("gap_addr1", d_addr.size() > 1 ? d_addr[1] : 64'hX, 64'd4);
      chk("gap_data1", d_data.size() > 1 ? d_data[1] : 64'hX, 64'hFEDC_BA98_7654_3210);
      chk("stop_in_load_done", done, 0);
      chk("stop_in_load_busy", busy, 1);
      stop_seen = 1'b0;

      // finish dmem, two imem words, reset with last write pulse in flight
      for (int i = 2; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = words[i];
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_wen", wen_ext, 1);
      arst_n = 1'b0;
      #1;
      chk("mid_rst_wen", wen_ext, 0);
      chk("mid_rst_addr", addr_ext, 0);
      chk("mid_rst_wdata", wdata_ext, 0);
      chk("mid_rst_flags", {in_ready, busy, done, cpu_enable, wen_ext_2}, 0);
      chk("mid_rst_cycles", cycles, 0);
      tick();
      arst_n = 1'b1;
      stop_seen = 1'b1;
      repeat (3) tick();
      chk("stop_in_idle_done", done, 0);
      stop_seen = 1'b0;

      clear_log();
      pulse_start();
      in_valid = 1'b1; in_data = 64'h0F0F_0F0F_0F0F_0F0F; tick();
      in_valid = 1'b0;
      tick();
      chk("reload_count", d_addr.size(), 1);
      chk("reload_addr0", d_addr.size() > 0 ? d_addr[0] : 64'hX, 64'd0);
      chk("reload_data0", d_data.size() > 0 ? d_data[0] : 64'hX, 64'h0F0F_0F0F_0F0F_0F0F);

      chk("port_exclusive", excl_err, 0);
      chk("ren_low", ren_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 512, instruction words to load.
REQ-002 Parameter DMEM_WORDS, default 1024, data words to load.
REQ-003 Parameter SETTLE_CYCLES, default 1, idle cycles between last write and cpu_enable rising.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse, begins a load sequence.
REQ-008 in_valid  in  1  in_data holds a word.
REQ-009 in_data  in  64  source word; imem phase uses bits [31:0] only.
REQ-010 in_ready  out  1  loader accepts in_data this cycle.
REQ-011 stop_seen  in  1  CPU fetched the stop opcode (instruction[6:0]==7'b1111110).
REQ-012 addr_ext / wen_ext / ren_ext / wdata_ext  out  64/1/1/32  CPU instruction-memory external port.
REQ-013 addr_ext_2 / wen_ext_2 / ren_ext_2 / wdata_ext_2  out  64/1/1/64  CPU data-memory external port.
REQ-014 cpu_enable  out  1  drives CPU enable.
REQ-015 busy  out  1  high in any state except IDLE and HALT.
REQ-016 done  out  1  high in HALT.
REQ-017 cycles  out  32  count of clk edges with cpu_enable high.

Function
REQ-018 States: IDLE, LOAD_DMEM, LOAD_IMEM, SETTLE, RUN, HALT.
REQ-019 IDLE or HALT + start -> LOAD_DMEM; clear word counter, settle counter and cycles; deassert cpu_enable. start ignored in other states.
REQ-020 in_ready = 1 exactly in LOAD_DMEM and LOAD_IMEM; one word accepted per cycle on in_valid & in_ready.
REQ-021 Accepted word n (0-based per phase) SHALL appear on the relevant port the next cycle: wen=1, addr=n<<2, wdata=in_data (imem: in_data[31:0]); otherwise wen=0, addr=0, wdata=0.
REQ-022 ren_ext and ren_ext_2 SHALL be 0 at all times.
REQ-023 Acceptance of word DMEM_WORDS-1 -> LOAD_IMEM, counter cleared; acceptance of word IMEM_WORDS-1 -> SETTLE.
REQ-024 in_valid low during a load phase: no write, counter holds, no timeout.
REQ-025 Counters n-bit wide, clog2 of word count; never wrap, because phase exits on last word.
REQ-026 SETTLE lasts SETTLE_CYCLES cycles after the last write pulse, then RUN; cpu_enable = 1 in RUN only.
REQ-027 RUN: cycles increments by 1 per clk edge, saturating at 32'hFFFFFFFF.
REQ-028 RUN + stop_seen -> HALT next edge; that edge still counts; cycles then frozen until next start.
REQ-029 stop_seen outside RUN SHALL be ignored.
REQ-030 Write ports SHALL be mutually exclusive: never wen_ext and wen_ext_2 high in the same cycle.

Reset
REQ-031 arst_n low SHALL immediately force state IDLE and all outputs to 0, including any in-flight write pulse.
REQ-032 Reset mid-load discards progress; next start reloads from word 0 of dmem.

Verification
REQ-033 Params IMEM=4, DMEM=4, SETTLE=1:
- start, then 8 back-to-back words D0..D3, I0..I3 -> wen_ext_2 at addr 0,4,8,12 with D0..D3; then wen_ext at 0,4,8,12 with I0[31:0]..I3[31:0]; cpu_enable rises 2 cycles after last wen_ext.
REQ-034 in_valid toggled 1,0,0,1 during dmem phase -> exactly 2 writes, addresses 0 then 4, no gaps in address.
REQ-035 stop_seen pulsed on 10th RUN cycle -> HALT, done=1, cpu_enable=0, cycles=10, held constant for 20 further cycles.
REQ-036 arst_n low after 2 imem words -> all outputs 0 within the same cycle; start again -> dmem write at addr 0.
REQ-037 start pulsed during LOAD_IMEM and RUN -> no state, counter or cycles change.
REQ-038 stop_seen high in IDLE/LOAD -> ignored, done stays 0.
